// File: rtl/ram_bist_pkg.sv
// Shared definitions for the RAM BIST controller: default geometry and FSM encoding.
package ram_bist_pkg;

  localparam int unsigned AddrWDefault = 2;
  localparam int unsigned DataWDefault = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWr   = 2'd1,
    StRd   = 2'd2,
    StDone = 2'd3
  } bist_state_e;

endpackage

// File: rtl/ram_bist_pattern.sv
// Expected-data generator: seed plus index, inverted on the second pass.
module ram_bist_pattern #(
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] seed_reg,
  input  logic [ADDR_W-1:0] idx,
  input  logic              pass_bit,
  output logic [DATA_W-1:0] expected
);

  logic [DATA_W-1:0] sum;

  // Sum is truncated to DATA_W, so the pattern wraps with no carry-out.
  assign sum      = seed_reg + DATA_W'(idx);
  assign expected = pass_bit ? ~sum : sum;

endmodule

// File: rtl/ram_bist_ctrl.sv
// March-style RAM BIST: write/read pass with true data, then with inverted data.
module ram_bist_ctrl
  import ram_bist_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDefault,
  parameter int unsigned DATA_W = DataWDefault
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        err_count
);

  bist_state_e       state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              pass_bit_q, pass_bit_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic [2:0]        err_q, err_d;
  logic [ADDR_W-1:0] fail_q, fail_d;
  logic              pass_q, pass_d;

  logic [DATA_W-1:0] expected;
  logic              last_idx;
  logic              mismatch;

  ram_bist_pattern #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_pattern (
    .seed_reg (seed_q),
    .idx      (idx_q),
    .pass_bit (pass_bit_q),
    .expected (expected)
  );

  assign last_idx = &idx_q;
  assign mismatch = (mem_rdata != expected);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pass_bit_d = pass_bit_q;
    seed_d     = seed_q;
    err_d      = err_q;
    fail_d     = fail_q;
    pass_d     = pass_q;
    mem_rw     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    busy       = 1'b0;
    done       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          seed_d     = seed;
          err_d      = '0;
          fail_d     = '0;
          pass_d     = 1'b0;
          pass_bit_d = 1'b0;
          idx_d      = '0;
          state_d    = StWr;
        end
      end
      StWr: begin
        busy      = 1'b1;
        mem_rw    = 1'b1;
        mem_addr  = idx_q;
        mem_wdata = expected;
        idx_d     = idx_q + 1'b1;
        if (last_idx) state_d = StRd;
      end
      StRd: begin
        busy     = 1'b1;
        mem_addr = idx_q;
        idx_d    = idx_q + 1'b1;
        if (mismatch) begin
          if (err_q != 3'd7) err_d = err_q + 3'd1;
          if (err_q == 3'd0) fail_d = idx_q;
        end
        if (last_idx) begin
          if (!pass_bit_q) begin
            pass_bit_d = 1'b1;
            state_d    = StWr;
          end else begin
            // Include this cycle's compare in the verdict.
            pass_d  = (err_q == 3'd0) && !mismatch;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      pass_bit_q <= 1'b0;
      seed_q     <= '0;
      err_q      <= '0;
      fail_q     <= '0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pass_bit_q <= pass_bit_d;
      seed_q     <= seed_d;
      err_q      <= err_d;
      fail_q     <= fail_d;
      pass_q     <= pass_d;
    end
  end

  assign pass      = pass_q;
  assign fail_addr = fail_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Directed bench for ram_bist_ctrl with a 4x8 RAM model and selectable fault modes.
module tb_ram_bist_ctrl;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       start = 1'b0;
  logic [7:0] seed = 8'h00;
  logic       mem_rw;
  logic [1:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       busy, done, pass;
  logic [1:0] fail_addr;
  logic [2:0] err_count;

  int n_checks = 0;
  int n_fail   = 0;

  // 0 = good RAM, 1 = addr 2 bit0 stuck at 0, 2 = reads always return 0
  int         fault = 0;
  logic [7:0] mem [4];
  logic [7:0] wlog [$];

  always #5 clk = ~clk;

  ram_bist_ctrl dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .seed      (seed),
    .mem_rw    (mem_rw),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_addr (fail_addr),
    .err_count (err_count)
  );

  always @(posedge clk) begin
    if (mem_rw) mem[mem_addr] <= (fault == 1 && mem_addr == 2'd2) ? (mem_wdata & 8'hFE) : mem_wdata;
  end

  always_comb begin
    mem_rdata = 8'h00;
    if (!mem_rw && fault != 2) mem_rdata = mem[mem_addr];
  end

  always @(negedge clk) begin
    if (mem_rw) wlog.push_back(mem_wdata);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_rw"},    32'(mem_rw),    32'h0);
    check({tag, "_addr"},  32'(mem_addr),  32'h0);
    check({tag, "_wdata"}, 32'(mem_wdata), 32'h0);
    check({tag, "_busy"},  32'(busy),      32'h0);
    check({tag, "_done"},  32'(done),      32'h0);
    check({tag, "_pass"},  32'(pass),      32'h0);
    check({tag, "_fail"},  32'(fail_addr), 32'h0);
    check({tag, "_err"},   32'(err_count), 32'h0);
  endtask

  // Runs one full test; exp_w lists the 8 writes, first write in the top byte.
  task automatic run_test(input string tag, input logic [7:0] s, input int restart,
                          input logic [63:0] exp_w, input logic exp_pass,
                          input logic [2:0] exp_err, input logic [1:0] exp_fail);
    wlog.delete();
    @(negedge clk);
    seed  = s;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_on"}, 32'(busy), 32'h1);
    for (int c = 1; c <= 15; c++) begin
      if (c == restart) begin
        start = 1'b1;
        seed  = 8'h00;
      end
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
    end
    check({tag, "_done_early"}, 32'(done), 32'h0);
    check({tag, "_busy_last"},  32'(busy), 32'h1);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_done"},      32'(done),      32'h1);
    check({tag, "_busy_done"}, 32'(busy),      32'h0);
    check({tag, "_pass"},      32'(pass),      32'(exp_pass));
    check({tag, "_err"},       32'(err_count), 32'(exp_err));
    check({tag, "_fail"},      32'(fail_addr), 32'(exp_fail));
    check({tag, "_nwrites"},   32'(wlog.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < wlog.size())
        check($sformatf("%s_w%0d", tag, i), 32'(wlog[i]), 32'(exp_w[8*(7-i) +: 8]));
    end
    @(posedge clk);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'h0);
    check({tag, "_pass_held"},  32'(pass), 32'(exp_pass));
  endtask

  initial begin
    #2;
    check_idle_zero("reset");
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);

    fault = 0;
    run_test("good", 8'hA1, 0, 64'hA1A2A3A4_5E5D5C5B, 1'b1, 3'd0, 2'd0);

    fault = 1;
    run_test("stuck", 8'hA1, 0, 64'hA1A2A3A4_5E5D5C5B, 1'b0, 3'd1, 2'd2);

    fault = 0;
    run_test("wrap", 8'hFE, 0, 64'hFEFF0001_0100FFFE, 1'b1, 3'd0, 2'd0);

    run_test("restart", 8'hA1, 5, 64'hA1A2A3A4_5E5D5C5B, 1'b1, 3'd0, 2'd0);

    // Abort during the pass-1 read phase.
    @(negedge clk);
    seed  = 8'hA1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (13) @(posedge clk);
    @(negedge clk);
    check("midrd_busy", 32'(busy), 32'h1);
    clr = 1'b1;
    #1;
    check_idle_zero("clr_async");
    @(negedge clk);
    clr = 1'b0;
    repeat (3) @(negedge clk);
    check("no_resume_busy", 32'(busy), 32'h0);
    check("no_resume_rw",   32'(mem_rw), 32'h0);
    run_test("after_clr", 8'h10, 0, 64'h10111213_EFEEEDEC, 1'b1, 3'd0, 2'd0);

    fault = 2;
    run_test("zero", 8'h01, 0, 64'h01020304_FEFDFCFB, 1'b0, 3'd7, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no end of test required finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
